// File: rtl/incremental_ds_modulator_if.sv
// -----------------------------------------------------------------------------
// incremental_ds_modulator_if
// Word-in / bitstream-out bundle for the incremental delta-sigma modulator.
//   in_data   : unsigned word to encode (master -> slave)
//   in_valid  : in_data valid (master -> slave)
//   in_ready  : modulator can accept a word this cycle (slave -> master)
//   bit_out   : modulator output bit (slave -> master)
//   bit_valid : bit_out is a conversion sample (slave -> master)
//   bit_first : bit_out is sample 0 of a conversion (slave -> master)
//   bit_last  : bit_out is the final sample of a conversion (slave -> master)
// -----------------------------------------------------------------------------
interface incremental_ds_modulator_if #(
    parameter int DATA_W = 12
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic              bit_out;
    logic              bit_valid;
    logic              bit_first;
    logic              bit_last;

    modport master (
        output in_data, in_valid,
        input  in_ready, bit_out, bit_valid, bit_first, bit_last
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, bit_out, bit_valid, bit_first, bit_last
    );
endinterface

// File: rtl/incremental_ds_modulator.sv
// -----------------------------------------------------------------------------
// incremental_ds_modulator
// Digital incremental delta-sigma modulator (1st or 2nd order). Each accepted
// word clears the integrators and produces exactly OSR one-bit samples whose
// ones-density is word / 2^DATA_W.
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   s_bus : slave side of incremental_ds_modulator_if (word in, bits out)
// -----------------------------------------------------------------------------
module incremental_ds_modulator #(
    parameter int DATA_W = 12,
    parameter int OSR    = 512,
    parameter int ORDER  = 2,
    parameter int INT_W  = 18
) (
    input  logic                       clk,
    input  logic                       rst_n,
    incremental_ds_modulator_if.slave  s_bus
);
    localparam int CNT_W = $clog2(OSR);
    // Two guard bits hold integrator + x - FS without overflow before clamping.
    localparam int EXT_W = INT_W + 2;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam logic [CNT_W-1:0]        C_LAST    = CNT_W'(OSR - 1);
    localparam logic signed [EXT_W-1:0] C_FS      = {{(EXT_W-DATA_W-1){1'b0}}, 1'b1, {DATA_W{1'b0}}};
    localparam logic signed [EXT_W-1:0] C_MAX_EXT = {3'b000, {(INT_W-1){1'b1}}};
    localparam logic signed [EXT_W-1:0] C_MIN_EXT = {3'b111, {(INT_W-1){1'b0}}};
    localparam logic signed [INT_W-1:0] C_MAX     = {1'b0, {(INT_W-1){1'b1}}};
    localparam logic signed [INT_W-1:0] C_MIN     = {1'b1, {(INT_W-1){1'b0}}};

    if (ORDER != 1 && ORDER != 2) begin : g_bad_order
        $error("incremental_ds_modulator: ORDER must be 1 or 2");
    end

    function automatic logic signed [INT_W-1:0] sat_int(input logic signed [EXT_W-1:0] v);
        if (v > C_MAX_EXT)
            sat_int = C_MAX;
        else if (v < C_MIN_EXT)
            sat_int = C_MIN;
        else
            sat_int = v[INT_W-1:0];
    endfunction

    function automatic logic is_pos(input logic signed [INT_W-1:0] v);
        is_pos = !v[INT_W-1] && (v != '0);
    endfunction

    logic [0:0]              r_state;
    logic [CNT_W-1:0]        r_count;
    logic [DATA_W-1:0]       r_x;
    logic signed [INT_W-1:0] r_i1;
    logic signed [INT_W-1:0] r_i2;
    logic                    r_fb;
    logic                    r_bit_out;
    logic                    r_bit_valid;
    logic                    r_bit_first;
    logic                    r_bit_last;

    logic                    w_last;
    logic                    w_in_ready;
    logic                    w_accept;
    logic                    w_q;
    logic signed [EXT_W-1:0] w_f;
    logic signed [EXT_W-1:0] w_x_ext;
    logic signed [EXT_W-1:0] w_i1_sum;
    logic signed [EXT_W-1:0] w_i2_sum;
    logic signed [INT_W-1:0] w_i1n;
    logic signed [INT_W-1:0] w_i2n;

    assign w_last     = (r_count == C_LAST);
    assign w_in_ready = rst_n & ((r_state == S_IDLE) | ((r_state == S_RUN) & w_last));
    assign w_accept   = w_in_ready & s_bus.in_valid;

    // Loop step from pre-edge state; the saturated values feed both the
    // quantiser and the registers.
    always_comb begin
        w_f      = r_fb ? C_FS : '0;
        w_x_ext  = {{(EXT_W-DATA_W){1'b0}}, r_x};
        w_i1_sum = {{2{r_i1[INT_W-1]}}, r_i1} + w_x_ext - w_f;
        w_i1n    = sat_int(w_i1_sum);
        w_i2_sum = '0;
        w_i2n    = '0;
        w_q      = is_pos(w_i1n);
        if (ORDER == 2) begin
            w_i2_sum = {{2{r_i2[INT_W-1]}}, r_i2} + {{2{w_i1n[INT_W-1]}}, w_i1n} - w_f;
            w_i2n    = sat_int(w_i2_sum);
            w_q      = is_pos(w_i2n);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_count     <= '0;
            r_x         <= '0;
            r_i1        <= '0;
            r_i2        <= '0;
            r_fb        <= 1'b0;
            r_bit_out   <= 1'b0;
            r_bit_valid <= 1'b0;
            r_bit_first <= 1'b0;
            r_bit_last  <= 1'b0;
        end else begin
            if (r_state == S_RUN) begin
                r_i1        <= w_i1n;
                r_i2        <= w_i2n;
                r_fb        <= w_q;
                r_bit_out   <= w_q;
                r_bit_valid <= 1'b1;
                r_bit_first <= (r_count == '0);
                r_bit_last  <= w_last;
                // OSR is a power of two, so the counter wraps to 0 after the last step.
                r_count     <= r_count + 1'b1;
                if (w_last)
                    r_state <= S_IDLE;
            end else begin
                r_bit_valid <= 1'b0;
                r_bit_first <= 1'b0;
                r_bit_last  <= 1'b0;
            end
            // An accept on the last step overrides the step's integrator
            // update so the next word starts from a clean loop.
            if (w_accept) begin
                r_x     <= s_bus.in_data;
                r_i1    <= '0;
                r_i2    <= '0;
                r_fb    <= 1'b0;
                r_count <= '0;
                r_state <= S_RUN;
            end
        end
    end

    assign s_bus.in_ready  = w_in_ready;
    assign s_bus.bit_out   = r_bit_out;
    assign s_bus.bit_valid = r_bit_valid;
    assign s_bus.bit_first = r_bit_first;
    assign s_bus.bit_last  = r_bit_last;
endmodule

// File: tb/tb_incremental_ds_modulator.sv
// -----------------------------------------------------------------------------
// tb_incremental_ds_modulator
// Bench for incremental_ds_modulator: one ORDER=2 and one ORDER=1 instance
// sharing clock and reset. Expected bits for the ORDER=2 instance come from a
// behavioural loop model queued at stimulus time.
// -----------------------------------------------------------------------------
module tb_incremental_ds_modulator;
    localparam int     DATA_W = 12;
    localparam int     OSR    = 512;
    localparam int     INT_W  = 18;
    localparam longint FS     = 4096;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    bit   sb2[$];
    bit   bits[OSR];
    int   ones_half = 0;

    always #5 clk = ~clk;

    incremental_ds_modulator_if #(.DATA_W(DATA_W)) bus2();
    incremental_ds_modulator_if #(.DATA_W(DATA_W)) bus1();

    incremental_ds_modulator #(.DATA_W(DATA_W), .OSR(OSR), .ORDER(2), .INT_W(INT_W)) dut2 (
        .clk(clk), .rst_n(rst_n), .s_bus(bus2)
    );
    incremental_ds_modulator #(.DATA_W(DATA_W), .OSR(OSR), .ORDER(1), .INT_W(INT_W)) dut1 (
        .clk(clk), .rst_n(rst_n), .s_bus(bus1)
    );

    // Second-order loop model; pushes the OSR expected bits of one word.
    function automatic void model_push(input longint x);
        longint i1, i2, f, hi, lo;
        bit     fb, q;
        i1 = 0; i2 = 0; fb = 1'b0;
        hi = (longint'(1) << (INT_W - 1)) - 1;
        lo = -(longint'(1) << (INT_W - 1));
        for (int k = 0; k < OSR; k++) begin
            f  = fb ? FS : 0;
            i1 = i1 + x - f;
            if (i1 > hi) i1 = hi; else if (i1 < lo) i1 = lo;
            i2 = i2 + i1 - f;
            if (i2 > hi) i2 = hi; else if (i2 < lo) i2 = lo;
            q  = (i2 > 0);
            fb = q;
            sb2.push_back(q);
        end
    endfunction

    // One full ORDER=2 conversion from IDLE, scoreboard-checked sample by sample.
    task automatic test_conv2(input string name, input logic [DATA_W-1:0] x, output int ones);
        int got, c0, c1;
        bit e;
        logic [3:0] obs, want;
        got = 0; ones = 0; c0 = 0; c1 = 0;
        sb2.delete();
        model_push(longint'(x));
        bus2.in_data  = x;
        bus2.in_valid = 1'b1;
        @(negedge clk);
        bus2.in_valid = 1'b0;
        checks++;
        if (bus2.bit_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_latency: bit_valid=%b want 0", name, bus2.bit_valid);
        end
        for (int c = 0; c < OSR + 16 && got < OSR; c++) begin
            @(negedge clk);
            if (bus2.bit_valid === 1'b1) begin
                if (sb2.size() > 0) e = sb2.pop_front(); else e = 1'b0;
                obs  = {bus2.bit_out, bus2.bit_first, bus2.bit_last, bus2.in_ready};
                want = {e, got == 0, got == OSR - 1, got >= OSR - 2};
                checks++;
                if (obs !== want) begin
                    errors++;
                    $display("FAIL %s_s%0d: {bit,first,last,ready}=%b want %b", name, got, obs, want);
                end
                bits[got] = bus2.bit_out;
                ones += int'(bus2.bit_out);
                if (got == 0) c0 = c;
                c1 = c;
                got++;
            end
        end
        checks++;
        if (got != OSR || c1 - c0 != OSR - 1) begin
            errors++;
            $display("FAIL %s_count: samples=%0d span=%0d want %0d span %0d", name, got, c1 - c0, OSR, OSR - 1);
        end
    endtask

    task automatic test_reset;
        logic [4:0] obs;
        rst_n = 1'b0;
        bus2.in_valid = 1'b1; bus2.in_data = 12'd2048;
        bus1.in_valid = 1'b0; bus1.in_data = '0;
        repeat (2) @(negedge clk);
        obs = {bus2.in_ready, bus2.bit_valid, bus2.bit_out, bus2.bit_first, bus2.bit_last};
        checks++;
        if (obs !== 5'b0) begin errors++; $display("FAIL reset_o2: {ready,valid,bit,first,last}=%b want 00000", obs); end
        obs = {bus1.in_ready, bus1.bit_valid, bus1.bit_out, bus1.bit_first, bus1.bit_last};
        checks++;
        if (obs !== 5'b0) begin errors++; $display("FAIL reset_o1: {ready,valid,bit,first,last}=%b want 00000", obs); end
        rst_n = 1'b1;
        bus2.in_valid = 1'b0;
        #1;
        checks++;
        if ({bus2.in_ready, bus1.in_ready} !== 2'b11) begin
            errors++; $display("FAIL reset_release_ready: {o2,o1}=%b want 11", {bus2.in_ready, bus1.in_ready});
        end
        @(negedge clk);
        checks++;
        if ({bus2.bit_valid, bus2.in_ready} !== 2'b01) begin
            errors++; $display("FAIL reset_idle: {valid,ready}=%b want 01", {bus2.bit_valid, bus2.in_ready});
        end
    endtask

    task automatic test_zero;
        int ones;
        test_conv2("zero", 12'd0, ones);
        checks++;
        if (ones != 0) begin errors++; $display("FAIL zero_ones: got %0d want 0", ones); end
    endtask

    task automatic test_half;
        bit want;
        test_conv2("half2", 12'd2048, ones_half);
        checks++;
        if (ones_half != 256) begin errors++; $display("FAIL half2_ones: got %0d want 256", ones_half); end
        for (int k = 0; k < OSR; k++) begin
            want = (k % 4 == 0) || (k % 4 == 3);
            checks++;
            if (bits[k] !== want) begin errors++; $display("FAIL half2_pat%0d: got %b want %b", k, bits[k], want); end
        end
        @(negedge clk);
        checks++;
        if ({bus2.bit_valid, bus2.bit_first, bus2.bit_last, bus2.bit_out} !== 4'b0001) begin
            errors++;
            $display("FAIL idle_hold: {valid,first,last,bit}=%b want 0001",
                     {bus2.bit_valid, bus2.bit_first, bus2.bit_last, bus2.bit_out});
        end
    endtask

    task automatic test_order1;
        int got, ones, c0, c1;
        logic [2:0] obs, want;
        got = 0; ones = 0; c0 = 0; c1 = 0;
        bus1.in_data = 12'd2048; bus1.in_valid = 1'b1;
        @(negedge clk);
        bus1.in_valid = 1'b0;
        checks++;
        if (bus1.bit_valid !== 1'b0) begin errors++; $display("FAIL o1_latency: bit_valid=%b want 0", bus1.bit_valid); end
        for (int c = 0; c < OSR + 16 && got < OSR; c++) begin
            @(negedge clk);
            if (bus1.bit_valid === 1'b1) begin
                obs  = {bus1.bit_out, bus1.bit_first, bus1.bit_last};
                want = {got % 2 == 0, got == 0, got == OSR - 1};
                checks++;
                if (obs !== want) begin errors++; $display("FAIL o1_s%0d: {bit,first,last}=%b want %b", got, obs, want); end
                ones += int'(bus1.bit_out);
                if (got == 0) c0 = c;
                c1 = c;
                got++;
            end
        end
        checks++;
        if (got != OSR || c1 - c0 != OSR - 1 || ones != 256) begin
            errors++;
            $display("FAIL o1_summary: samples=%0d span=%0d ones=%0d want %0d %0d 256", got, c1 - c0, ones, OSR, OSR - 1);
        end
    endtask

    task automatic test_back_to_back;
        int got, ones2, c0, c1, k;
        bit e;
        logic [3:0] obs, want;
        got = 0; ones2 = 0; c0 = 0; c1 = 0;
        sb2.delete();
        model_push(2048);
        model_push(0);
        bus2.in_data = 12'd2048; bus2.in_valid = 1'b1;
        @(negedge clk);
        bus2.in_data = 12'd0;
        checks++;
        if ({bus2.bit_valid, bus2.in_ready} !== 2'b00) begin
            errors++; $display("FAIL b2b_start: {valid,ready}=%b want 00", {bus2.bit_valid, bus2.in_ready});
        end
        for (int c = 0; c < 2 * OSR + 16 && got < 2 * OSR; c++) begin
            @(negedge clk);
            if (bus2.bit_valid === 1'b1) begin
                k = got % OSR;
                if (sb2.size() > 0) e = sb2.pop_front(); else e = 1'b0;
                obs  = {bus2.bit_out, bus2.bit_first, bus2.bit_last, bus2.in_ready};
                want = {e, k == 0, k == OSR - 1, (got < OSR) ? (got == OSR - 2) : (k >= OSR - 2)};
                checks++;
                if (obs !== want) begin
                    errors++;
                    $display("FAIL b2b_s%0d: {bit,first,last,ready}=%b want %b", got, obs, want);
                end
                if (got == OSR - 1) bus2.in_valid = 1'b0;
                if (got >= OSR) ones2 += int'(bus2.bit_out);
                if (got == 0) c0 = c;
                c1 = c;
                got++;
            end
        end
        checks++;
        if (got != 2 * OSR || c1 - c0 != 2 * OSR - 1 || ones2 != 0) begin
            errors++;
            $display("FAIL b2b_summary: samples=%0d span=%0d ones2=%0d want %0d %0d 0", got, c1 - c0, ones2, 2 * OSR, 2 * OSR - 1);
        end
    endtask

    task automatic test_quarter;
        int ones, diff;
        test_conv2("q1024", 12'd1024, ones);
        diff = ones_half - 2 * ones;
        checks++;
        if (ones < 126 || ones > 130 || diff < -2 || diff > 2) begin
            errors++;
            $display("FAIL q1024_ratio: ones=%0d half=%0d want 128+-2 and ratio 2", ones, ones_half);
        end
    endtask

    task automatic test_reset_mid;
        int got, ones;
        bit e, want;
        got = 0;
        sb2.delete();
        model_push(2048);
        bus2.in_data = 12'd2048; bus2.in_valid = 1'b1;
        @(negedge clk);
        bus2.in_valid = 1'b0;
        for (int c = 0; c < OSR && got <= 100; c++) begin
            @(negedge clk);
            if (bus2.bit_valid === 1'b1) begin
                if (sb2.size() > 0) e = sb2.pop_front(); else e = 1'b0;
                checks++;
                if ({bus2.bit_out, bus2.bit_first} !== {e, got == 0}) begin
                    errors++;
                    $display("FAIL rmid_s%0d: {bit,first}=%b want %b", got, {bus2.bit_out, bus2.bit_first}, {e, got == 0});
                end
                got++;
            end
        end
        checks++;
        if (got != 101) begin errors++; $display("FAIL rmid_reach: samples=%0d want 101", got); end
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus2.bit_valid, bus2.bit_first, bus2.bit_last, bus2.bit_out, bus2.in_ready} !== 5'b0) begin
            errors++;
            $display("FAIL rmid_reset: {valid,first,last,bit,ready}=%b want 00000",
                     {bus2.bit_valid, bus2.bit_first, bus2.bit_last, bus2.bit_out, bus2.in_ready});
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (bus2.in_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready: in_ready=%b want 1", bus2.in_ready); end
        test_conv2("rmid_new", 12'd2048, ones);
        for (int j = 0; j < 8; j++) begin
            want = (j % 4 == 0) || (j % 4 == 3);
            checks++;
            if (bits[j] !== want) begin errors++; $display("FAIL rmid_pat%0d: got %b want %b", j, bits[j], want); end
        end
    endtask

    initial begin
        bus2.in_valid = 1'b0; bus2.in_data = '0;
        bus1.in_valid = 1'b0; bus1.in_data = '0;
        test_reset();
        test_zero();
        test_half();
        test_order1();
        test_back_to_back();
        test_quarter();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
